id_digit_scanner: RTL and testbench
===================================

// Module: id_digit_scanner
// PURPOSE
//  Sequencer and display stage around the combinational ID-digit ROM (3-bit index in, 4-bit digit out).
//  - Upstream role: steps the ROM index 0..NUM_DIGITS-1 and captures every digit into a local buffer.
//  - Downstream role: time-multiplexes the buffered digits onto a one-hot digit-enable bus and a 7-segment bus.
//  Replaces the ad-hoc index sweep used in unit benches with synthesizable hardware.
// PARAMETERS
//  NUM_DIGITS  8  digits loaded and scanned; must be in 2..2**IDX_W
//  IDX_W       3  ROM index width
//  DIG_W       4  ROM digit width
//  PRESCALE    4  clk cycles each digit stays enabled during scan; must be >= 1
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-low
//  start      in   1           1-cycle request: (re)load buffer from ROM
//  rom_idx    out  IDX_W       index driven to the ROM (registered)
//  rom_digit  in   DIG_W       ROM data, combinational from rom_idx
//  busy       out  1           high while loading
//  loaded     out  1           high while buffer valid and scanning
//  err        out  1           sticky: a captured digit was > 9
//  digit_en   out  NUM_DIGITS  one-hot digit enable, active-high
//  seg        out  7           segments {g,f,e,d,c,b,a}, active-high
// BEHAVIOUR
//  Reset (rst=0, async): all of the following clear immediately, regardless of clk:
//   - state=IDLE; rom_idx=0; busy=0; loaded=0; err=0; digit_en=0; seg=0
//   - buffer all zeros; scan pointer p=0; prescaler=0
//   - a load or scan in progress is abandoned, no partial state survives
//  States:
//   IDLE: outputs blank. start=1 -> LOAD, with rom_idx=0, busy=1, err=0.
//   LOAD: each cycle buf[rom_idx]<=rom_digit; rom_idx<=rom_idx+1; err|=(rom_digit>9).
//     - The edge capturing index NUM_DIGITS-1 moves to SCAN: rom_idx=0, busy=0, loaded=1, p=0, prescaler=0.
//     - Load takes exactly NUM_DIGITS cycles. start is ignored in LOAD.
//     - digit_en=0 and seg=0 throughout LOAD.
//   SCAN:
//     - Prescaler counts 0..PRESCALE-1 and wraps; on the terminal count p advances.
//     - p wraps NUM_DIGITS-1 -> 0.
//     - Registered outputs: digit_en<=1<<p; seg<=decode(buf[p]).
//     - First valid outputs appear 1 cycle after the SCAN entry edge. Each digit then holds exactly PRESCALE cycles.
//     - start=1 -> LOAD: loaded=0, busy=1, err=0, outputs blank from the next edge.
//  Decode (hex):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   Digits > 9 decode to seg=00 (blank); err stays set until the next start.
//  rom_idx wraps only via the explicit reset to 0; it never exceeds NUM_DIGITS-1.
//  busy and loaded are never both 1.
// TESTING
//  ROM model: idx 0..7 -> 1,9,7,6,0,3,1,9.
//  1) Reset, no start, 50 cycles -> digit_en=0, seg=0, busy=0, loaded=0, rom_idx=0.
//  2) 1-cycle start pulse -> busy=1 for 8 cycles, rom_idx steps 0..7;
//     then loaded=1 and digit_en=01 with seg=06 for 4 cycles,
//     then digit_en=02 with seg=6F.
//  3) Scan 2 full rotations (64 cycles) -> digit_en goes 01,02,..,80,01;
//     seg matches 06,6F,07,7D,3F,4F,06,6F; err=0.
//  4) Change ROM idx3 to 12 and pulse start mid-scan -> outputs blank during the 8 load cycles;
//     afterwards err=1 and seg=00 while digit_en=08.
//  5) Assert rst=0 for 1 ns mid-load (between edges) -> all outputs 0 immediately;
//     no rotation resumes without a new start.
//  6) Pulse start at cycles 2 and 5 of a load -> ignored; load still completes in 8 cycles.

Source files
------------

// File: rtl/id_digit_scanner.sv
// id_digit_scanner
//   Loads NUM_DIGITS digits from a combinational ID-digit ROM into a local
//   buffer, then time-multiplexes them onto a one-hot digit enable and a
//   7-segment bus.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   start      1-cycle request to (re)load the buffer from the ROM
//   rom_idx    registered index driven to the ROM
//   rom_digit  ROM data, combinational from rom_idx
//   busy       high while loading
//   loaded     high while the buffer is valid and scanning
//   err        sticky: a captured digit was > 9 (cleared by start)
//   digit_en   one-hot digit enable, active-high
//   seg        segments {g,f,e,d,c,b,a}, active-high
module id_digit_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = 3,
  parameter int DIG_W      = 4,
  parameter int PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IDX_W-1:0]      rom_idx,
  input  logic [DIG_W-1:0]      rom_digit,
  output logic                  busy,
  output logic                  loaded,
  output logic                  err,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [6:0]            seg
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

  state_t              state, state_nx;
  logic [DIG_W-1:0]    dbuf [NUM_DIGITS];
  logic [IDX_W-1:0]    p;
  logic [PW-1:0]       presc;
  logic                last_idx;

  assign last_idx = (rom_idx == IDX_W'(NUM_DIGITS - 1));

  function automatic logic [6:0] decode(input logic [DIG_W-1:0] d);
    logic [6:0] s;
    s = '0;
    case (int'(d))
      0: s = 7'h3F;
      1: s = 7'h06;
      2: s = 7'h5B;
      3: s = 7'h4F;
      4: s = 7'h66;
      5: s = 7'h6D;
      6: s = 7'h7D;
      7: s = 7'h07;
      8: s = 7'h7F;
      9: s = 7'h6F;
      default: s = '0;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)    state_nx = LOAD;
      LOAD:    if (last_idx) state_nx = SCAN;
      SCAN:    if (start)    state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_idx  <= '0;
      busy     <= 1'b0;
      loaded   <= 1'b0;
      err      <= 1'b0;
      digit_en <= '0;
      seg      <= '0;
      p        <= '0;
      presc    <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) dbuf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          digit_en <= '0;
          seg      <= '0;
          if (start) begin
            rom_idx <= '0;
            busy    <= 1'b1;
            err     <= 1'b0;
          end
        end
        LOAD: begin
          digit_en      <= '0;
          seg           <= '0;
          dbuf[rom_idx] <= rom_digit;
          err           <= err | (rom_digit > DIG_W'(9));
          if (last_idx) begin
            rom_idx <= '0;
            busy    <= 1'b0;
            loaded  <= 1'b1;
            p       <= '0;
            presc   <= '0;
          end else begin
            rom_idx <= rom_idx + IDX_W'(1);
          end
        end
        SCAN: begin
          if (start) begin
            rom_idx  <= '0;
            loaded   <= 1'b0;
            busy     <= 1'b1;
            err      <= 1'b0;
            digit_en <= '0;
            seg      <= '0;
          end else begin
            // Outputs lag p by one edge, so each digit is shown for the
            // PRESCALE edges starting one cycle after p moved to it.
            digit_en <= NUM_DIGITS'(1) << p;
            seg      <= decode(dbuf[p]);
            if (presc == PW'(PRESCALE - 1)) begin
              presc <= '0;
              if (p == IDX_W'(NUM_DIGITS - 1)) p <= '0;
              else                             p <= p + IDX_W'(1);
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        default: begin
          digit_en <= '0;
          seg      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_digit_scanner.sv
module tb_id_digit_scanner;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] rom_idx;
  logic [3:0] rom_digit;
  logic       busy;
  logic       loaded;
  logic       err;
  logic [7:0] digit_en;
  logic [6:0] seg;

  logic [3:0] rom [8];
  int checks   = 0;
  int failures = 0;

  assign rom_digit = rom[rom_idx];

  id_digit_scanner #(
    .NUM_DIGITS(8),
    .IDX_W(3),
    .DIG_W(4),
    .PRESCALE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rom_idx(rom_idx),
    .rom_digit(rom_digit),
    .busy(busy),
    .loaded(loaded),
    .err(err),
    .digit_en(digit_en),
    .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Hand-decoded segments for ROM 1,9,7,6,0,3,1,9 and with idx3 = 12.
  logic [6:0] seg_a [8];
  logic [6:0] seg_b [8];

  initial begin
    seg_a = '{7'h06, 7'h6F, 7'h07, 7'h7D, 7'h3F, 7'h4F, 7'h06, 7'h6F};
    seg_b = '{7'h06, 7'h6F, 7'h07, 7'h00, 7'h3F, 7'h4F, 7'h06, 7'h6F};
    rom   = '{4'd1, 4'd9, 4'd7, 4'd6, 4'd0, 4'd3, 4'd1, 4'd9};
    rst   = 1'b0;
    start = 1'b0;
    #23;
    chk("rst_digit_en", 32'(digit_en), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b1;

    // 1) idle without start
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 10 == 9) begin
        chk("idle_digit_en", 32'(digit_en), 0);
        chk("idle_seg", 32'(seg), 0);
      end
    end
    chk("idle_busy", 32'(busy), 0);
    chk("idle_loaded", 32'(loaded), 0);
    chk("idle_rom_idx", 32'(rom_idx), 0);

    // 2) load sequence
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("load_busy", 32'(busy), 1);
      chk("load_idx", 32'(rom_idx), 32'(k));
      chk("load_blank", 32'(digit_en), 0);
      tick();
    end
    chk("scan_entry_loaded", 32'(loaded), 1);
    chk("scan_entry_busy", 32'(busy), 0);
    chk("scan_entry_idx", 32'(rom_idx), 0);
    chk("scan_entry_blank", 32'(digit_en), 0);
    tick();

    // 3) two full rotations
    for (int j = 0; j < 64; j++) begin
      chk("scan_digit_en", 32'(digit_en), 32'(8'd1 << ((j / 4) % 8)));
      chk("scan_seg", 32'(seg), 32'(seg_a[(j / 4) % 8]));
      tick();
    end
    chk("scan_wrap", 32'(digit_en), 32'h01);
    chk("scan_err", 32'(err), 0);

    // 4) reload mid-scan with an invalid digit
    rom[3] = 4'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("reload_busy", 32'(busy), 1);
      chk("reload_loaded", 32'(loaded), 0);
      chk("reload_digit_en", 32'(digit_en), 0);
      chk("reload_seg", 32'(seg), 0);
      tick();
    end
    chk("reload_err", 32'(err), 1);
    chk("reload_done", 32'(loaded), 1);
    tick();
    for (int j = 0; j < 32; j++) begin
      chk("bad_digit_en", 32'(digit_en), 32'(8'd1 << ((j / 4) % 8)));
      chk("bad_seg", 32'(seg), 32'(seg_b[(j / 4) % 8]));
      tick();
    end
    chk("bad_err_sticky", 32'(err), 1);

    // 5) asynchronous reset in the middle of a load
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_idx", 32'(rom_idx), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_loaded", 32'(loaded), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_idx", 32'(rom_idx), 0);
    chk("arst_digit_en", 32'(digit_en), 0);
    chk("arst_seg", 32'(seg), 0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 8 == 7) begin
        chk("post_rst_digit_en", 32'(digit_en), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_loaded", 32'(loaded), 0);
      end
    end

    // 6) start pulses during load are ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("ign_busy", 32'(busy), 1);
      chk("ign_idx", 32'(rom_idx), 32'(k));
      start = (k == 2 || k == 5) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    chk("ign_loaded", 32'(loaded), 1);
    chk("ign_busy_done", 32'(busy), 0);
    tick();
    chk("ign_first_digit", 32'(digit_en), 32'h01);
    chk("ign_first_seg", 32'(seg), 32'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
